// File: rtl/cordic_iter_engine.sv
// Iterative CORDIC rotation engine (linear MAC / hyperbolic cosh-sinh).
// Ports: clk, rst, start, mode, x/y/z_in -> x/y/z_out, busy, done; ROM rom_i/rom_sel/rom_data.
module cordic_iter_engine #(
    parameter int WIDTH = 15,
    parameter int FRAC  = 10,
    parameter int ITER  = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               mode,
    input  logic signed [WIDTH:0] x_in,
    input  logic signed [WIDTH:0] y_in,
    input  logic signed [WIDTH:0] z_in,
    output logic [3:0]         rom_i,
    output logic               rom_sel,
    input  logic signed [WIDTH:0] rom_data,
    output logic signed [WIDTH:0] x_out,
    output logic signed [WIDTH:0] y_out,
    output logic signed [WIDTH:0] z_out,
    output logic               busy,
    output logic               done
);

    // Data words must keep at least one integer bit above the fraction.
    if (FRAC >= WIDTH) begin : g_frac_check
        $error("FRAC leaves no integer bits");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       rep_q, rep_d;
    logic       sel_q, sel_d;
    logic signed [WIDTH:0] x_q, x_d;
    logic signed [WIDTH:0] y_q, y_d;
    logic signed [WIDTH:0] z_q, z_d;
    logic signed [WIDTH:0] xo_q, xo_d;
    logic signed [WIDTH:0] yo_q, yo_d;
    logic signed [WIDTH:0] zo_q, zo_d;

    logic [3:0]            shamt;
    logic                  neg;
    logic signed [WIDTH:0] xs, ys;
    logic signed [WIDTH:0] nx, ny, nz;

    // One micro-rotation; linear mode shifts by cnt-1 so the first
    // step uses the full x (weight 1.0) and x itself never changes.
    always_comb begin
        shamt = sel_q ? cnt_q : cnt_q - 4'd1;
        neg   = z_q[WIDTH];
        xs    = x_q >>> shamt;
        ys    = y_q >>> shamt;
        if (sel_q) begin
            nx = neg ? x_q - ys : x_q + ys;
        end else begin
            nx = x_q;
        end
        ny = neg ? y_q - xs : y_q + xs;
        nz = neg ? z_q + rom_data : z_q - rom_data;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rep_d   = rep_q;
        sel_d   = sel_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        xo_d    = xo_q;
        yo_d    = yo_q;
        zo_d    = zo_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sel_d   = mode;
                    x_d     = x_in;
                    y_d     = y_in;
                    z_d     = z_in;
                    cnt_d   = 4'd1;
                    rep_d   = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                x_d = nx;
                y_d = ny;
                z_d = nz;
                // Hyperbolic CORDIC needs index 4 applied twice to converge.
                if (sel_q && cnt_q == 4'd4 && !rep_q) begin
                    rep_d = 1'b1;
                end else if (cnt_q == 4'(ITER)) begin
                    cnt_d   = 4'd1;
                    xo_d    = nx;
                    yo_d    = ny;
                    zo_d    = nz;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE: begin
                sel_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd1;
            rep_q   <= 1'b0;
            sel_q   <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            xo_q    <= '0;
            yo_q    <= '0;
            zo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rep_q   <= rep_d;
            sel_q   <= sel_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            xo_q    <= xo_d;
            yo_q    <= yo_d;
            zo_q    <= zo_d;
        end
    end

    // cnt_q rests at 1 outside RUN, so the index is a plain flop output.
    assign rom_i   = cnt_q;
    assign rom_sel = sel_q;
    assign x_out   = xo_q;
    assign y_out   = yo_q;
    assign z_out   = zo_q;
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);

endmodule

// File: tb/tb_cordic_iter_engine.sv
// Scoreboard bench for cordic_iter_engine with a behavioural ROM and model.
// Stimulus pushes expected results; a negedge monitor pops and compares.
module tb_cordic_iter_engine;

    logic clk = 1'b0;
    logic rst, start, mode;
    logic signed [15:0] x_in, y_in, z_in, rom_data;
    logic signed [15:0] x_out, y_out, z_out;
    logic [3:0] rom_i;
    logic rom_sel, busy, done;

    cordic_iter_engine #(.WIDTH(15), .FRAC(10), .ITER(10)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .x_in(x_in), .y_in(y_in), .z_in(z_in),
        .rom_i(rom_i), .rom_sel(rom_sel), .rom_data(rom_data),
        .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic signed [15:0] x, y, z;
        logic m;
        int due;
    } exp_t;
    exp_t exp_q[$];

    // Linear table: 2^-(i-1); hyperbolic table: atanh(2^-i); both Q.10.
    function automatic logic signed [15:0] rom_val(logic sel, logic [3:0] i);
        int hy[10] = '{562, 262, 129, 64, 32, 16, 8, 4, 2, 1};
        if (i < 4'd1 || i > 4'd10) return 16'sd0;
        if (sel) return 16'(hy[i - 1]);
        return 16'(1024 >> (i - 1));
    endfunction

    always_comb rom_data = rom_val(rom_sel, rom_i);

    function automatic int wrap16(int v);
        logic signed [15:0] t;
        t = 16'(v);
        return int'(t);
    endfunction

    function automatic void idx_seq(logic m, ref int seq[$]);
        seq.delete();
        for (int i = 1; i <= 10; i++) begin
            seq.push_back(i);
            if (m && i == 4) seq.push_back(4);
        end
    endfunction

    function automatic exp_t model(logic m, int x, int y, int z, int due);
        int seq[$];
        int xn, yn, zn, d, s;
        exp_t e;
        idx_seq(m, seq);
        foreach (seq[k]) begin
            d = (z >= 0) ? 1 : -1;
            s = m ? seq[k] : seq[k] - 1;
            xn = m ? wrap16(x + d * (y >>> s)) : x;
            yn = wrap16(y + d * (x >>> s));
            zn = wrap16(z - d * int'(rom_val(m, 4'(seq[k]))));
            x = xn;
            y = yn;
            z = zn;
        end
        e.x = 16'(x);
        e.y = 16'(y);
        e.z = 16'(z);
        e.m = m;
        e.due = due;
        return e;
    endfunction

    function automatic void chk(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endfunction

    function automatic void chk_tol(string name, int act, int req, int tol);
        int diff;
        diff = act - req;
        if (diff < 0) diff = -diff;
        total++;
        if (diff > tol) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d+/-%0d", name, act, req, tol);
        end
    endfunction

    // Monitor
    int trace[$];
    logic signed [15:0] last_x = 0, last_y = 0, last_z = 0;

    always @(negedge clk) begin
        if (rst) begin
            trace.delete();
            last_x = 0;
            last_y = 0;
            last_z = 0;
        end else if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                int seq[$];
                int tr_ok;
                e = exp_q.pop_front();
                chk("x_out", x_out, e.x);
                chk("y_out", y_out, e.y);
                chk("z_out", z_out, e.z);
                chk("latency", cyc, e.due);
                chk("done_rom_i", rom_i, 1);
                chk("done_rom_sel", rom_sel, e.m);
                idx_seq(e.m, seq);
                tr_ok = (trace.size() == seq.size()) ? 1 : 0;
                if (tr_ok == 1) begin
                    foreach (seq[k]) if (trace[k] != seq[k]) tr_ok = 0;
                end
                chk("rom_i_trace", tr_ok, 1);
            end
            trace.delete();
            last_x = x_out;
            last_y = y_out;
            last_z = z_out;
        end else if (busy) begin
            trace.push_back(int'(rom_i));
            if (exp_q.size() == 0) begin
                chk("busy_without_op", 1, 0);
            end else begin
                chk("run_rom_sel", rom_sel, exp_q[0].m);
            end
            chk("hold_x", x_out, last_x);
            chk("hold_y", y_out, last_y);
            chk("hold_z", z_out, last_z);
        end else begin
            chk("idle_rom_i", rom_i, 1);
            chk("idle_rom_sel", rom_sel, 0);
        end
    end

    // Stimulus
    task automatic tick(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(logic m, int x, int y, int z);
        int n = 0;
        while (busy && n < 50) begin
            tick(1);
            n++;
        end
        if (busy) chk("issue_timeout", 1, 0);
        mode = m;
        x_in = 16'(x);
        y_in = 16'(y);
        z_in = 16'(z);
        start = 1'b1;
        exp_q.push_back(model(m, x, y, z, cyc + 1 + (m ? 11 : 10)));
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 40) begin
            tick(1);
            n++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        tick(15);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        mode = 1'b0;
        x_in = 0;
        y_in = 0;
        z_in = 0;
        tick(2);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_x", x_out, 0);
        chk("rst_y", y_out, 0);
        chk("rst_z", z_out, 0);
        chk("rst_rom_i", rom_i, 1);
        chk("rst_rom_sel", rom_sel, 0);

        issue(1'b0, 1536, 0, 512);
        wait_done();
        chk_tol("lin_y", y_out, 768, 4);
        chk("lin_x", x_out, 1536);

        issue(1'b0, 1024, 0, -256);
        wait_done();
        chk_tol("lin_neg_y", y_out, -256, 2);

        issue(1'b1, 1237, 0, 512);
        wait_done();
        chk_tol("hyp_cosh", x_out, 1155, 4);
        chk_tol("hyp_sinh", y_out, 534, 4);
        drain();

        // A second start inside RUN must be dropped.
        issue(1'b0, 1000, 200, -300);
        tick(2);
        mode = 1'b1;
        x_in = 16'sd77;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done();
        drain();

        // Reset mid-operation discards it.
        issue(1'b1, 1237, 0, 256);
        tick(4);
        rst = 1'b1;
        exp_q.delete();
        tick(1);
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_x", x_out, 0);
        chk("midrst_y", y_out, 0);
        chk("midrst_z", z_out, 0);
        issue(1'b0, 800, 100, 300);
        wait_done();
        drain();

        // Back-to-back: next start in the cycle right after done.
        issue(1'b0, 1500, -50, 700);
        wait_done();
        issue(1'b1, 1237, 100, -400);
        wait_done();
        drain();

        for (int k = 0; k < 40; k++) begin
            logic m;
            int x, y, z;
            m = 1'($urandom_range(0, 1));
            x = int'($urandom_range(0, 8000)) - 4000;
            y = int'($urandom_range(0, 8000)) - 4000;
            if (m) z = int'($urandom_range(0, 2200)) - 1100;
            else z = int'($urandom_range(0, 4000)) - 2000;
            issue(m, x, y, z);
            if ($urandom_range(0, 3) == 0) tick(int'($urandom_range(1, 5)));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
